exec_unit_mc: RTL and testbench

//  Next-generation execute stage: width-parametrised ALU with registered output, valid/ready

---
 rtl/exec_unit_mc.sv | 194 +++++++++++++++++++
 tb/tb_exec_unit_mc.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit_mc.sv
// Execute stage: single-cycle ALU ops plus iterative MUL/DIVU behind valid/ready handshakes.
// The result/flags register and the held carry survive flush; only the handshake state is aborted.
module exec_unit_mc #(
  parameter int WIDTH  = 16,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic             imm_sel,
  input  logic [WIDTH-1:0] reg_src,
  input  logic [WIDTH-1:0] reg_dst,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d;
  logic             div_q, div_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             carry_q, carry_d;

  logic             accept, is_multi;
  logic [WIDTH+1:0] alu_res;
  logic [WIDTH:0]   mul_sum, rem_sh;

  // Returns {V, C, result}; cin is the held carry for ops that leave C untouched.
  function automatic logic [WIDTH+1:0] alu_eval(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a, b, s,
                                                input logic sel, cin);
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] r;
    logic             c, v;
    wide = '0;
    r    = '0;
    c    = cin;
    v    = 1'b0;
    case (op)
      4'h1: begin
        wide = {1'b0, b} - {1'b0, a};
        r = wide[WIDTH-1:0];
        c = wide[WIDTH];
        v = (b[WIDTH-1] != a[WIDTH-1]) && (r[WIDTH-1] != b[WIDTH-1]);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: begin
        wide = {1'b0, a} << s;
        r = wide[WIDTH-1:0];
        c = wide[WIDTH];
      end
      4'h5: begin
        // The guard bit below A catches the last bit shifted out.
        wide = {a, 1'b0} >> s;
        r = wide[WIDTH:1];
        c = wide[0];
      end
      4'h6: r = ~a;
      4'h7: r = sel ? b : s;
      4'h8: begin
        wide = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
        r = wide[WIDTH-1:0];
        c = wide[WIDTH];
        v = !a[WIDTH-1] && r[WIDTH-1];
      end
      4'h9: begin
        wide = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
        r = wide[WIDTH-1:0];
        c = wide[WIDTH];
        v = a[WIDTH-1] && !r[WIDTH-1];
      end
      4'hA: r = a;
      default: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[WIDTH-1:0];
        c = wide[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
    endcase
    return {v, c, r};
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    a_d         = a_q;
    div_d       = div_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    carry_d     = carry_q;
    mul_sum     = '0;
    rem_sh      = '0;

    in_ready = (state_q == IDLE) && (!out_valid_q || out_ready) && !flush;
    accept   = in_valid && in_ready;
    is_multi = (alu_op == 4'hB) || (DIV_EN && (alu_op == 4'hC));
    alu_res  = alu_eval(alu_op, reg_src, reg_dst, imm, imm_sel, carry_q);

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      if (out_ready) out_valid_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && is_multi) begin
            state_d = BUSY;
            cnt_d   = '0;
            a_d     = reg_src;
            lo_d    = reg_dst;
            hi_d    = '0;
            div_d   = (alu_op == 4'hC);
          end else if (accept) begin
            result_d    = alu_res[WIDTH-1:0];
            flags_d     = {alu_res[WIDTH+1], alu_res[WIDTH], alu_res[WIDTH-1],
                           alu_res[WIDTH-1:0] == '0};
            carry_d     = alu_res[WIDTH];
            out_valid_d = 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q == CW'(WIDTH)) begin
            state_d     = IDLE;
            result_d    = lo_q;
            flags_d     = {div_q && (a_q == '0), !div_q && (|hi_q), lo_q[WIDTH-1], lo_q == '0};
            carry_d     = !div_q && (|hi_q);
            out_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (div_q) begin
              // Restoring division: lo shifts the dividend out and the quotient in.
              rem_sh = {hi_q, lo_q[WIDTH-1]};
              if (rem_sh >= {1'b0, a_q}) begin
                hi_d = WIDTH'(rem_sh - {1'b0, a_q});
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
              end else begin
                hi_d = rem_sh[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
              end
            end else begin
              mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
              hi_d    = mul_sum[WIDTH:1];
              lo_d    = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      carry_q     <= carry_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      a_q         <= a_d;
      div_q       <= div_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign busy      = (state_q == BUSY);
endmodule

// File: tb/tb_exec_unit_mc.sv
// Bench for exec_unit_mc: driver queues hand-computed {result,flags}; a monitor pops on each handshake.
module tb_exec_unit_mc;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_op = '0;
  logic         imm_sel = 1'b0;
  logic [W-1:0] reg_src = '0, reg_dst = '0, imm = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  logic [W+3:0] exp_q[$];
  string        name_q[$];

  exec_unit_mc #(.WIDTH(W), .DIV_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .imm_sel(imm_sel), .reg_src(reg_src), .reg_dst(reg_dst), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Monitor: every accepted output must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got res=%h flags=%b, want no output", result, flags);
      end else begin
        logic [W+3:0] e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if ({result, flags} !== e) begin
          bad++;
          $display("FAIL %s: got res=%h flags=%b, want res=%h flags=%b",
                   nm, result, flags, e[W+3:4], e[3:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, b, im, input logic sel,
                       input logic [W-1:0] er, input logic [3:0] ef, input bit push,
                       input string nm);
    int n;
    alu_op = op; reg_src = a; reg_dst = b; imm = im; imm_sel = sel; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk({nm, "_accept_timeout"}, 32'(in_ready), 32'd1);
    end else begin
      acc_cyc = cyc + 1;
      if (push) begin
        exp_q.push_back({er, ef});
        name_q.push_back(nm);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Back-to-back single-cycle ops; expected flags are {V,C,N,Z}.
    issue(4'h0, 16'h7FFF, 16'h0001, 16'h0000, 0, 16'h8000, 4'b1010, 1, "add_ovf");
    issue(4'h1, 16'h0005, 16'h0003, 16'h0000, 0, 16'hFFFE, 4'b0110, 1, "sub_borrow");
    issue(4'h2, 16'hF0F0, 16'h0F0F, 16'h0000, 0, 16'h0000, 4'b0101, 1, "and_held_c");
    issue(4'h5, 16'h0003, 16'h0000, 16'd1,    0, 16'h0001, 4'b0100, 1, "shr_1");
    issue(4'h5, 16'h0003, 16'h0000, 16'd20,   0, 16'h0000, 4'b0001, 1, "shr_20");
    issue(4'h4, 16'h8001, 16'h0000, 16'd16,   0, 16'h0000, 4'b0101, 1, "shl_16");
    issue(4'h3, 16'h1200, 16'h0034, 16'h0000, 0, 16'h1234, 4'b0100, 1, "or");
    issue(4'h6, 16'h0000, 16'h0000, 16'h0000, 0, 16'hFFFF, 4'b0110, 1, "not");
    issue(4'h7, 16'h5555, 16'h00AB, 16'h1111, 1, 16'h00AB, 4'b0100, 1, "passb_reg");
    issue(4'h7, 16'h5555, 16'h00AB, 16'h0000, 0, 16'h0000, 4'b0101, 1, "passb_imm");
    issue(4'h8, 16'hFFFF, 16'h0000, 16'h0000, 0, 16'h0000, 4'b0101, 1, "inc_wrap");
    issue(4'h9, 16'h0000, 16'h0000, 16'h0000, 0, 16'hFFFF, 4'b0110, 1, "dec_borrow");
    issue(4'h9, 16'h8000, 16'h0000, 16'h0000, 0, 16'h7FFF, 4'b1000, 1, "dec_ovf");
    issue(4'hA, 16'h8000, 16'h0000, 16'h0000, 0, 16'h8000, 4'b0010, 1, "passa");
    issue(4'hD, 16'hFFFF, 16'h0001, 16'h0000, 0, 16'h0000, 4'b0101, 1, "opD_add");
    issue(4'h4, 16'h0001, 16'h0000, 16'h0000, 0, 16'h0001, 4'b0000, 1, "shl_0");
    issue(4'h1, 16'h0001, 16'h8000, 16'h0000, 0, 16'h7FFF, 4'b1000, 1, "sub_ovf");
    drain();

    // MUL latency and busy/in_ready while iterating.
    issue(4'hB, 16'h0100, 16'h0100, 16'h0000, 0, 16'h0000, 4'b0101, 1, "mul_hi");
    @(negedge clk);
    chk("mul_busy", 32'(busy), 1);
    chk("mul_in_ready", 32'(in_ready), 0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mul_latency", 32'(cyc - acc_cyc), 32'd17);
    @(posedge clk); #1;
    issue(4'hB, 16'h0003, 16'h0005, 16'h0000, 0, 16'h000F, 4'b0000, 1, "mul_small");
    issue(4'hC, 16'd7,    16'd100,  16'h0000, 0, 16'h000E, 4'b0000, 1, "divu");
    issue(4'hC, 16'h0000, 16'h1234, 16'h0000, 0, 16'hFFFF, 4'b1010, 1, "divu_zero");
    drain();

    // Output stall with a waiting request.
    out_ready = 1'b0;
    issue(4'h0, 16'h0001, 16'h0002, 16'h0000, 0, 16'h0003, 4'b0000, 1, "stall_first");
    alu_op = 4'h0; reg_src = 16'hFFFF; reg_dst = 16'h0002; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_result", 32'(result), 32'h0003);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(4'h0, 16'hFFFF, 16'h0002, 16'h0000, 0, 16'h0001, 4'b0100, 1, "stall_second");
    drain();

    // Flush mid-MUL: no output, result and held carry retained.
    issue(4'hB, 16'h0003, 16'h0005, 16'h0000, 0, 16'h0000, 4'b0000, 0, "mul_flushed");
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_in_ready_after", 32'(in_ready), 1);
    chk("flush_result_kept", 32'(result), 32'h0001);
    repeat (25) @(negedge clk);
    @(posedge clk); #1;
    issue(4'h2, 16'hFFFF, 16'h8000, 16'h0000, 0, 16'h8000, 4'b0110, 1, "and_after_flush");
    drain();

    // Reset mid-DIVU: everything back to reset values, held carry cleared.
    issue(4'hC, 16'h0003, 16'h0009, 16'h0000, 0, 16'h0000, 4'b0000, 0, "div_reset");
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_out_valid", 32'(out_valid), 0);
    chk("rst_mid_result", 32'(result), 0);
    chk("rst_mid_flags", 32'(flags), 0);
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    issue(4'h2, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 4'b0001, 1, "and_after_rst");
    drain();

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
